// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between two requesters with round-robin arbitration.
// The ALU result is captured the cycle after issue into one-entry response slots,
// each carrying its own zero flag and an overflow flag recomputed from the
// operand sign bits kept in the stage register. This is needed because the
// ALU's own overflow output is already stale when the result arrives.
module alu_share_arbiter #(
  parameter logic [5:0] OP_ADD  = 6'h20,
  parameter logic [5:0] OP_SUB  = 6'h22,
  parameter logic [5:0] OP_IDLE = 6'h3f
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op0,
  input  logic [5:0]  req_op1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  output logic [5:0]  alu_control,
  output logic [31:0] alu_src0,
  output logic [31:0] alu_src1,
  input  logic [31:0] alu_result,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_data0,
  output logic [31:0] resp_data1,
  output logic [1:0]  resp_zero,
  output logic [1:0]  resp_ov
);

  logic        stageValid_q, stageValid_d;
  logic        stageTag_q, stageTag_d;
  logic        stageAdd_q, stageAdd_d;
  logic        stageSub_q, stageSub_d;
  logic        stageA31_q, stageA31_d;
  logic        stageB31_q, stageB31_d;
  logic        favour_q, favour_d;
  logic [1:0]  respValid_q, respValid_d;
  logic [1:0]  respZero_q, respZero_d;
  logic [1:0]  respOv_q, respOv_d;
  logic [31:0] respData0_q, respData0_d;
  logic [31:0] respData1_q, respData1_d;

  logic [1:0]  eligible;
  logic [1:0]  candidate;
  logic [1:0]  grant;
  logic        grantIdx;
  logic        capOv;
  logic        capZero;

  // Arbitration: a requester with a pending op or an undrained slot waits; ties go to the favoured one.
  always_comb begin
    eligible  = 2'b00;
    candidate = 2'b00;
    grant     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = !(stageValid_q && (stageTag_q == i[0])) &&
                    (!respValid_q[i] || resp_ready[i]);
    end
    if (!reset) begin
      candidate = req_valid & eligible;
    end
    if (candidate == 2'b11) begin
      grant = favour_q ? 2'b10 : 2'b01;
    end else begin
      grant = candidate;
    end
    grantIdx  = grant[1];
    req_ready = grant;
    favour_d  = favour_q;
    if (grant != 2'b00) begin
      favour_d = ~grantIdx;
    end
  end

  // ALU input mux and stage-register next state for the op being issued this cycle.
  always_comb begin
    alu_control = OP_IDLE;
    alu_src0    = 32'd0;
    alu_src1    = 32'd0;
    if (grant[0]) begin
      alu_control = req_op0;
      alu_src0    = req_a0;
      alu_src1    = req_b0;
    end else if (grant[1]) begin
      alu_control = req_op1;
      alu_src0    = req_a1;
      alu_src1    = req_b1;
    end
    stageValid_d = (grant != 2'b00);
    stageTag_d   = grantIdx;
    stageAdd_d   = stageValid_d && (alu_control == OP_ADD);
    stageSub_d   = stageValid_d && (alu_control == OP_SUB);
    stageA31_d   = alu_src0[31];
    stageB31_d   = alu_src1[31];
  end

  // Capture the ALU result into the tagged slot, otherwise drain slots the requester accepts.
  always_comb begin
    capZero = (alu_result == 32'd0);
    capOv   = 1'b0;
    if (stageAdd_q) begin
      capOv = (stageA31_q == stageB31_q) && (alu_result[31] != stageA31_q);
    end else if (stageSub_q) begin
      capOv = (stageA31_q != stageB31_q) && (alu_result[31] != stageA31_q);
    end
    respValid_d = respValid_q;
    respZero_d  = respZero_q;
    respOv_d    = respOv_q;
    respData0_d = respData0_q;
    respData1_d = respData1_q;
    for (int i = 0; i < 2; i++) begin
      if (stageValid_q && (stageTag_q == i[0])) begin
        respValid_d[i] = 1'b1;
        respZero_d[i]  = capZero;
        respOv_d[i]    = capOv;
      end else if (resp_ready[i]) begin
        respValid_d[i] = 1'b0;
      end
    end
    if (stageValid_q && !stageTag_q) begin
      respData0_d = alu_result;
    end
    if (stageValid_q && stageTag_q) begin
      respData1_d = alu_result;
    end
  end

  // State registers; reset discards any in-flight op and buffered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid_q <= 1'b0;
      stageTag_q   <= 1'b0;
      stageAdd_q   <= 1'b0;
      stageSub_q   <= 1'b0;
      stageA31_q   <= 1'b0;
      stageB31_q   <= 1'b0;
      favour_q     <= 1'b0;
      respValid_q  <= 2'b00;
      respZero_q   <= 2'b00;
      respOv_q     <= 2'b00;
      respData0_q  <= 32'd0;
      respData1_q  <= 32'd0;
    end else begin
      stageValid_q <= stageValid_d;
      stageTag_q   <= stageTag_d;
      stageAdd_q   <= stageAdd_d;
      stageSub_q   <= stageSub_d;
      stageA31_q   <= stageA31_d;
      stageB31_q   <= stageB31_d;
      favour_q     <= favour_d;
      respValid_q  <= respValid_d;
      respZero_q   <= respZero_d;
      respOv_q     <= respOv_d;
      respData0_q  <= respData0_d;
      respData1_q  <= respData1_d;
    end
  end

  assign resp_valid = respValid_q;
  assign resp_zero  = respZero_q;
  assign resp_ov    = respOv_q;
  assign resp_data0 = respData0_q;
  assign resp_data1 = respData1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a simple registered ALU model attached.
module tb_alu_share_arbiter;

  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SLT  = 6'h2a;
  localparam logic [5:0] OP_IDLE = 6'h3f;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [5:0]  alu_control;
  logic [31:0] alu_src0, alu_src1;
  logic [31:0] alu_result;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data0, resp_data1;
  logic [1:0]  resp_zero, resp_ov;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_IDLE(OP_IDLE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .alu_control(alu_control), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data0(resp_data0), .resp_data1(resp_data1),
    .resp_zero(resp_zero), .resp_ov(resp_ov)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Registered ALU stand-in: result appears the cycle after the operands are driven.
  always @(posedge clk) begin
    case (alu_control)
      OP_ADD:  alu_result <= alu_src0 + alu_src1;
      OP_SUB:  alu_result <= alu_src0 - alu_src1;
      OP_SLT:  alu_result <= ($signed(alu_src0) < $signed(alu_src1)) ? 32'd1 : 32'd0;
      default: alu_result <= 32'd0;
    endcase
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [5:0] op0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [5:0] op1, input logic [31:0] a1,
                               input logic [31:0] b1);
    req_valid = valid;
    req_op0 = op0; req_a0 = a0; req_b0 = b0;
    req_op1 = op1; req_a1 = a1; req_b1 = b1;
    #1;
  endtask

  // Issue one op on requester idx and check its response two cycles later.
  task automatic runOp(input int idx, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expData, input logic expZero, input logic expOv);
    if (idx == 0) applyStimulus(2'b01, op, a, b, OP_IDLE, 32'd0, 32'd0);
    else          applyStimulus(2'b10, OP_IDLE, 32'd0, 32'd0, op, a, b);
    checkOutput("grant", {30'd0, req_ready}, (idx == 0) ? 32'd1 : 32'd2);
    checkOutput("aluCtl", {26'd0, alu_control}, {26'd0, op});
    tick();
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);
    checkOutput("idleCtl", {26'd0, alu_control}, {26'd0, OP_IDLE});
    tick();
    checkOutput("respValid", {31'd0, resp_valid[idx]}, 32'd1);
    checkOutput("respData", (idx == 0) ? resp_data0 : resp_data1, expData);
    checkOutput("respZero", {31'd0, resp_zero[idx]}, {31'd0, expZero});
    checkOutput("respOv", {31'd0, resp_ov[idx]}, {31'd0, expOv});
  endtask

  initial begin
    reset = 1'b1;
    resp_ready = 2'b11;
    applyStimulus(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd1, 32'd1);
    tick();
    tick();
    checkOutput("rstReady", {30'd0, req_ready}, 32'd0);
    checkOutput("rstAluCtl", {26'd0, alu_control}, {26'd0, OP_IDLE});
    checkOutput("rstRespValid", {30'd0, resp_valid}, 32'd0);
    checkOutput("rstData0", resp_data0, 32'd0);
    reset = 1'b0;
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);

    // Basic add and overflow cases.
    runOp(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    runOp(1, OP_ADD, 32'h7fffffff, 32'd1, 32'h80000000, 1'b0, 1'b1);
    runOp(1, OP_SUB, 32'h80000000, 32'd1, 32'h7fffffff, 1'b0, 1'b1);
    runOp(1, OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);

    // Both requesters valid: grants alternate every cycle.
    applyStimulus(2'b11, OP_ADD, 32'd10, 32'd1, OP_SUB, 32'd100, 32'd30);
    checkOutput("alt0", {30'd0, req_ready}, 32'd1);
    tick();
    checkOutput("alt1", {30'd0, req_ready}, 32'd2);
    tick();
    checkOutput("alt2", {30'd0, req_ready}, 32'd1);
    checkOutput("altData0", resp_data0, 32'd11);
    tick();
    checkOutput("alt3", {30'd0, req_ready}, 32'd2);
    checkOutput("altData1", resp_data1, 32'd70);
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // Back-pressure on requester 0 while requester 1 keeps issuing.
    resp_ready = 2'b10;
    applyStimulus(2'b01, OP_ADD, 32'd1, 32'd2, OP_IDLE, 32'd0, 32'd0);
    checkOutput("bpGrant", {30'd0, req_ready}, 32'd1);
    tick();
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);
    tick();
    applyStimulus(2'b11, OP_ADD, 32'd50, 32'd50, OP_SUB, 32'd9, 32'd4);
    for (int h = 0; h < 5; h++) begin
      checkOutput($sformatf("bpReady%0d", h), {30'd0, req_ready}, (h % 2 == 0) ? 32'd2 : 32'd0);
      checkOutput($sformatf("bpValid0_%0d", h), {31'd0, resp_valid[0]}, 32'd1);
      checkOutput($sformatf("bpData0_%0d", h), resp_data0, 32'd3);
      if (h == 2 || h == 4) checkOutput($sformatf("bpData1_%0d", h), resp_data1, 32'd5);
      tick();
    end
    resp_ready = 2'b11;
    #1;
    checkOutput("bpRelease", {30'd0, req_ready}, 32'd1);
    tick();
    checkOutput("bpAfter", {30'd0, req_ready}, 32'd2);
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("bpNewData0", resp_data0, 32'd100);

    // Reset one cycle after issue discards the op.
    applyStimulus(2'b10, OP_IDLE, 32'd0, 32'd0, OP_ADD, 32'd3, 32'd4);
    checkOutput("rmGrant", {30'd0, req_ready}, 32'd2);
    tick();
    reset = 1'b1;
    applyStimulus(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd1, 32'd1);
    checkOutput("rmReadyInReset", {30'd0, req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rmNoResp", {30'd0, resp_valid}, 32'd0);
    checkOutput("rmData1", resp_data1, 32'd0);
    checkOutput("rmFavour0", {30'd0, req_ready}, 32'd1);
    applyStimulus(2'b00, OP_IDLE, 32'd0, 32'd0, OP_IDLE, 32'd0, 32'd0);

    // SLT never reports overflow.
    runOp(0, OP_SLT, 32'hffffffff, 32'd1, 32'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
